// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and sizing helper shared by the multicycle ALU
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_MULT = 4'b0111;
  localparam logic [3:0] ALU_DIV  = 4'b1000;
  localparam logic [3:0] ALU_REM  = 4'b1001;

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/alu_muldiv_core.sv
// alu_muldiv_core: iterative shift-add multiplier / restoring divider on operand magnitudes
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             op_is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             last_o
);
  localparam int CW = clog2(WIDTH + 1);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] mul_sum, div_sh;
  logic div_ge;
  // Load seeds hi=0, lo=multiplier/dividend, op=multiplicand/divisor; each step retires one bit
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, op_q};
    hi_d  = hi_q;
    lo_d  = lo_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (load_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      op_d  = b_i;
      cnt_d = CW'(WIDTH);
    end else if (step_i) begin
      cnt_d = cnt_q - CW'(1);
      hi_d  = op_is_div_i ? (div_ge ? WIDTH'(div_sh - {1'b0, op_q}) : div_sh[WIDTH-1:0])
                          : mul_sum[WIDTH:1];
      lo_d  = op_is_div_i ? {lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end
  // Datapath and step counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end
  assign lo_o   = lo_q;
  assign hi_o   = hi_q;
  assign last_o = cnt_q == CW'(1);
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with 1-cycle logic/add/sub and iterative signed MULT/DIV/REM
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIGNED_MD = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [3:0]       iControlSignal,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oALUresult,
  output logic [WIDTH-1:0] oResultHi,
  output logic             oOverflow,
  output logic             oDivZero
);
  state_e state_q, state_d;
  logic [3:0] opc_q, opc_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
  logic ovf_q, ovf_d, dz_q, dz_d, done_q, done_d;
  logic is_md, dz, go, sa, sb, one_ovf, last, neg;
  logic [WIDTH-1:0] sum, dif, one_res, mag_a, mag_b, core_lo, core_hi, quo, rem, fin_res, fin_hi;
  logic [2*WIDTH-1:0] prod;

  assign is_md = iControlSignal == ALU_MULT || iControlSignal == ALU_DIV || iControlSignal == ALU_REM;
  assign dz    = (iControlSignal == ALU_DIV || iControlSignal == ALU_REM) && iB == '0;
  assign go    = is_md && !dz;
  assign sa    = (SIGNED_MD != 0) && iA[WIDTH-1];
  assign sb    = (SIGNED_MD != 0) && iB[WIDTH-1];
  assign mag_a = sa ? -iA : iA;
  assign mag_b = sb ? -iB : iB;
  assign sum   = iA + iB;
  assign dif   = iA - iB;
  assign one_res = iControlSignal == ALU_AND ? iA & iB :
                   iControlSignal == ALU_OR  ? iA | iB :
                   iControlSignal == ALU_ADD ? sum :
                   iControlSignal == ALU_SUB ? dif :
                   iControlSignal == ALU_XOR ? iA ^ iB :
                   iControlSignal == ALU_NOR ? ~(iA | iB) :
                   dz ? '1 : '0;
  assign one_ovf = iControlSignal == ALU_ADD ? (iA[WIDTH-1] == iB[WIDTH-1]) && (sum[WIDTH-1] != iA[WIDTH-1]) :
                   iControlSignal == ALU_SUB ? (iA[WIDTH-1] != iB[WIDTH-1]) && (dif[WIDTH-1] != iA[WIDTH-1]) :
                   1'b0;

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk_i      (iClk),
    .rst_ni     (iRst_n),
    .load_i     (state_q == IDLE && iStart && go),
    .step_i     (state_q == ITER),
    .op_is_div_i(opc_q != ALU_MULT),
    .a_i        (mag_a),
    .b_i        (mag_b),
    .lo_o       (core_lo),
    .hi_o       (core_hi),
    .last_o     (last)
  );

  // Sign fix-up: product and quotient negative iff signs differ, remainder follows the dividend
  assign neg     = sa_q ^ sb_q;
  assign prod    = neg ? -{core_hi, core_lo} : {core_hi, core_lo};
  assign quo     = neg ? -core_lo : core_lo;
  assign rem     = sa_q ? -core_hi : core_hi;
  assign fin_res = opc_q == ALU_MULT ? prod[WIDTH-1:0] : opc_q == ALU_DIV ? quo : rem;
  assign fin_hi  = opc_q == ALU_MULT ? prod[2*WIDTH-1:WIDTH] : rem;

  // Next state and output register updates; busy starts are silently ignored
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    hi_d    = hi_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (iStart) begin
        if (go) begin
          state_d = ITER;
          opc_d   = iControlSignal;
          sa_d    = sa;
          sb_d    = sb;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end else begin
          res_d  = one_res;
          hi_d   = dz ? iA : '0;
          ovf_d  = one_ovf;
          dz_d   = dz;
          done_d = 1'b1;
        end
      end
      ITER: if (last) state_d = FINISH;
      FINISH: begin
        state_d = IDLE;
        res_d   = fin_res;
        hi_d    = fin_hi;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      opc_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign oBusy      = state_q != IDLE;
  assign oDone      = done_q;
  assign oALUresult = res_q;
  assign oResultHi  = hi_q;
  assign oOverflow  = ovf_q;
  assign oDivZero   = dz_q;
endmodule
